// File: rtl/pipe_seq_ctrl.sv
// Central sequencer for an N-stage valid/stall pipeline: backward stall propagation,
// timed multi-cycle range flushes, graceful drain, source gating and debug event counters.
module pipe_seq_ctrl #(
  parameter int N_STAGES  = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_drain_req,
  input  logic [N_STAGES-1:0]         i_stall_req,
  input  logic [N_STAGES-1:0]         i_stage_valid,
  input  logic                        i_flush_req,
  input  logic [$clog2(N_STAGES)-1:0] i_flush_upto,
  input  logic                        i_src_valid,
  output logic                        o_src_ready,
  output logic [N_STAGES-1:0]         o_ce,
  output logic [N_STAGES-1:0]         o_flush,
  output logic [1:0]                  o_state,
  output logic                        o_drained,
  output logic [CNT_W-1:0]            o_stall_cnt,
  output logic [CNT_W-1:0]            o_flush_cnt
);

  localparam int TMR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [N_STAGES-1:0] flush_q, flush_nxt;
  logic [N_STAGES-1:0] hold, range_mask;
  logic [TMR_W-1:0]    tmr_q, tmr_nxt;
  logic                ret_drain_q, ret_drain_nxt;
  logic                drained_q, drained_nxt;
  logic                flush_acc;
  logic                active;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A stall at stage k freezes k and every younger stage behind it.
  always_comb begin
    hold       = '0;
    range_mask = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      hold[k]       = |(i_stall_req >> k);
      range_mask[k] = (k <= int'(i_flush_upto));
    end
  end

  assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_ce        = active ? ~hold : '0;
  assign o_src_ready = (state_q == ST_RUN) & ~hold[0];
  assign o_state     = state_q;
  assign o_flush     = flush_q;
  assign o_drained   = drained_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

  always_comb begin
    state_nxt     = state_q;
    flush_nxt     = flush_q;
    tmr_nxt       = tmr_q;
    ret_drain_nxt = ret_drain_q;
    drained_nxt   = 1'b0;
    flush_acc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_flush_req) begin
          state_nxt     = ST_FLUSH;
          flush_nxt     = range_mask;
          tmr_nxt       = TMR_W'(FLUSH_CYC - 1);
          ret_drain_nxt = 1'b0;
          flush_acc     = 1'b1;
        end else if (i_drain_req) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        // A new request widens the active range and restarts the hold time.
        if (i_flush_req) begin
          flush_nxt = flush_q | range_mask;
          tmr_nxt   = TMR_W'(FLUSH_CYC - 1);
          flush_acc = 1'b1;
        end else if (tmr_q == '0) begin
          state_nxt = ret_drain_q ? ST_DRAIN : ST_RUN;
          flush_nxt = '0;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_flush_req) begin
          state_nxt     = ST_FLUSH;
          flush_nxt     = range_mask;
          tmr_nxt       = TMR_W'(FLUSH_CYC - 1);
          ret_drain_nxt = 1'b1;
          flush_acc     = 1'b1;
        end else if (i_stage_valid == '0) begin
          state_nxt   = ST_IDLE;
          drained_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      flush_q     <= '0;
      tmr_q       <= '0;
      ret_drain_q <= 1'b0;
      drained_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      flush_q     <= flush_nxt;
      tmr_q       <= tmr_nxt;
      ret_drain_q <= ret_drain_nxt;
      drained_q   <= drained_nxt;
      if (active && (|i_stall_req)) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_acc)                flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed, table-driven bench for pipe_seq_ctrl plus hand sequences for async reset
// mid-flush and stall-counter saturation.
module tb_pipe_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start, i_drain_req, i_flush_req, i_src_valid;
  logic [3:0]  i_stall_req, i_stage_valid;
  logic [1:0]  i_flush_upto;
  logic        o_src_ready, o_drained;
  logic [3:0]  o_ce, o_flush;
  logic [1:0]  o_state;
  logic [15:0] o_stall_cnt, o_flush_cnt;

  int passed = 0;
  int total  = 0;

  pipe_seq_ctrl #(.N_STAGES(4), .FLUSH_CYC(2), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_drain_req(i_drain_req),
    .i_stall_req(i_stall_req), .i_stage_valid(i_stage_valid), .i_flush_req(i_flush_req),
    .i_flush_upto(i_flush_upto), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
    .o_ce(o_ce), .o_flush(o_flush), .o_state(o_state), .o_drained(o_drained),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        start, drain;
    logic [3:0]  stall, valid;
    logic        flush;
    logic [1:0]  upto;
    logic [1:0]  st;
    logic [3:0]  ce;
    logic        rdy;
    logic [3:0]  fl;
    logic        dr;
    logic [15:0] sc, fc;
  } vec_t;

  vec_t tbl[$];

  task automatic check_all(input string name, input logic [1:0] st, input logic [3:0] ce,
                           input logic rdy, input logic [3:0] fl, input logic dr,
                           input logic [15:0] sc, input logic [15:0] fc);
    total++;
    if (o_state === st && o_ce === ce && o_src_ready === rdy && o_flush === fl &&
        o_drained === dr && o_stall_cnt === sc && o_flush_cnt === fc) begin
      passed++;
    end else begin
      $display("FAIL %s: got st=%0d ce=%b rdy=%b fl=%b dr=%b sc=%0d fc=%0d, want st=%0d ce=%b rdy=%b fl=%b dr=%b sc=%0d fc=%0d",
               name, o_state, o_ce, o_src_ready, o_flush, o_drained, o_stall_cnt, o_flush_cnt,
               st, ce, rdy, fl, dr, sc, fc);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  initial begin
    //                start drain stall  valid  flush upto | st  ce     rdy fl     dr sc  fc
    tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'd0, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1000, 1'b0, 4'b0000, 1'b0, 16'd1, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1000, 1'b0, 4'b0000, 1'b0, 16'd2, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'd2, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 2'd2, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd2, 16'd1});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd2, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd2, 16'd1});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'd2, 16'd1});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 2'd2, 4'b0000, 1'b0, 4'b0001, 1'b0, 16'd2, 16'd2});
    tbl.push_back('{1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd2, 2'd2, 4'b0000, 1'b0, 4'b0111, 1'b0, 16'd2, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd2, 4'b0000, 1'b0, 4'b0111, 1'b0, 16'd2, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'd2, 16'd3});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 2'd0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'd2, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0, 2'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd3, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'd3, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd3, 16'd3});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd3, 16'd3});
    tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'd3, 16'd3});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3, 2'd2, 4'b0000, 1'b0, 4'b1111, 1'b0, 16'd3, 16'd4});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd2, 4'b0000, 1'b0, 4'b1111, 1'b0, 16'd3, 16'd4});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'd3, 16'd4});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 2'd0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'd3, 16'd4});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 2'd2, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd3, 16'd5});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd0, 2'd2, 4'b0000, 1'b0, 4'b0011, 1'b0, 16'd3, 16'd5});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b0, 16'd3, 16'd5});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'd3, 16'd5});

    i_rst_n = 1'b0; i_start = 1'b0; i_drain_req = 1'b0; i_flush_req = 1'b0;
    i_src_valid = 1'b1; i_stall_req = '0; i_stage_valid = '0; i_flush_upto = '0;
    repeat (2) @(posedge i_clk);
    #1 check_all("reset", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0, 16'd0);
    @(negedge i_clk) i_rst_n = 1'b1;

    foreach (tbl[i]) begin
      i_start = tbl[i].start; i_drain_req = tbl[i].drain; i_stall_req = tbl[i].stall;
      i_stage_valid = tbl[i].valid; i_flush_req = tbl[i].flush; i_flush_upto = tbl[i].upto;
      @(posedge i_clk);
      #1 check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].ce, tbl[i].rdy, tbl[i].fl,
                   tbl[i].dr, tbl[i].sc, tbl[i].fc);
    end

    // Async reset in the middle of a flush cycle, away from any clock edge.
    i_start = 1'b1; i_drain_req = 1'b0; i_stall_req = '0; i_stage_valid = '0; i_flush_req = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_flush_req = 1'b1; i_flush_upto = 2'd2;
    @(posedge i_clk); #1;
    check_all("flush_before_rst", 2'd2, 4'b0000, 1'b0, 4'b0111, 1'b0, 16'd3, 16'd6);
    i_flush_req = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 check_all("async_rst_mid_flush", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0, 16'd0);
    @(posedge i_clk); #1;
    check_all("rst_held", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0, 16'd0);
    @(negedge i_clk) i_rst_n = 1'b1;

    // Long stall to push the stall counter into saturation.
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_stall_req = 4'b0001;
    repeat (65534) @(posedge i_clk);
    #1 check_cnt("stall_cnt_fffe", o_stall_cnt, 16'hFFFE);
    @(posedge i_clk);
    #1 check_cnt("stall_cnt_ffff", o_stall_cnt, 16'hFFFF);
    repeat (5) @(posedge i_clk);
    #1 check_cnt("stall_cnt_sat", o_stall_cnt, 16'hFFFF);
    check_all("sat_state", 2'd1, 4'b1110, 1'b0, 4'b0000, 1'b0, 16'hFFFF, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
